// File: rtl/dpram_port_arbiter.sv
// Two-requester round-robin arbiters and command sequencer for a 32x16 dual-port RAM.
// Optional same-address write-to-read forwarding is built when DPRAM_ARB_FWD_EN is defined.

module dpram_port_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b0;
    else if (|gnt)
      ptr <= gnt[0];  // winner k hands priority to 1-k
  end

endmodule

module dpram_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wreq_0,
  input  logic          wreq_1,
  input  logic [AW-1:0] waddr_0,
  input  logic [AW-1:0] waddr_1,
  input  logic [DW-1:0] wdata_0,
  input  logic [DW-1:0] wdata_1,
  output logic          wgnt_0,
  output logic          wgnt_1,
  input  logic          rreq_0,
  input  logic          rreq_1,
  input  logic [AW-1:0] raddr_0,
  input  logic [AW-1:0] raddr_1,
  output logic          rgnt_0,
  output logic          rgnt_1,
  output logic          rvalid_0,
  output logic          rvalid_1,
  output logic [DW-1:0] rdata,
  output logic          mem_wr,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_dout
);

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  logic [1:0] wgnt;
  logic [1:0] rgnt;
  rd_tag_t    tag_cmd;
  rd_tag_t    tag_ret;

  dpram_port_rr2 u_warb (
    .clk (clk),
    .rst (rst),
    .req ({wreq_1, wreq_0}),
    .gnt (wgnt)
  );

  dpram_port_rr2 u_rarb (
    .clk (clk),
    .rst (rst),
    .req ({rreq_1, rreq_0}),
    .gnt (rgnt)
  );

  assign wgnt_0 = wgnt[0];
  assign wgnt_1 = wgnt[1];
  assign rgnt_0 = rgnt[0];
  assign rgnt_1 = rgnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_wr <= |wgnt;
      if (|wgnt) begin
        mem_waddr <= wgnt[1] ? waddr_1 : waddr_0;
        mem_wdata <= wgnt[1] ? wdata_1 : wdata_0;
      end
    end
  end

  // tag_cmd rides alongside mem_rd; tag_ret lines up with mem_dout one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd    <= 1'b0;
      mem_raddr <= '0;
      tag_cmd   <= '0;
      tag_ret   <= '0;
    end else begin
      mem_rd  <= |rgnt;
      tag_cmd <= '{valid: |rgnt, id: rgnt[1]};
      tag_ret <= tag_cmd;
      if (|rgnt)
        mem_raddr <= rgnt[1] ? raddr_1 : raddr_0;
    end
  end

  assign rvalid_0 = tag_ret.valid && !tag_ret.id;
  assign rvalid_1 = tag_ret.valid &&  tag_ret.id;

`ifdef DPRAM_ARB_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  // The RAM returns pre-write contents on a same-address collision; substitute the new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= mem_wr && mem_rd && (mem_waddr == mem_raddr);
      fwd_data <= mem_wdata;
    end
  end

  assign rdata = fwd_hit ? fwd_data : mem_dout;
`else
  assign rdata = mem_dout;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter: RAM model, expectation queues and a decoupled output monitor.
// Expected collision data follows DPRAM_ARB_FWD_EN the same way the design build does.

module tb_dpram_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          wreq_0, wreq_1;
  logic [AW-1:0] waddr_0, waddr_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          wgnt_0, wgnt_1;
  logic          rreq_0, rreq_1;
  logic [AW-1:0] raddr_0, raddr_1;
  logic          rgnt_0, rgnt_1;
  logic          rvalid_0, rvalid_1;
  logic [DW-1:0] rdata;
  logic          mem_wr;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_dout;

  dpram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wreq_0    (wreq_0),
    .wreq_1    (wreq_1),
    .waddr_0   (waddr_0),
    .waddr_1   (waddr_1),
    .wdata_0   (wdata_0),
    .wdata_1   (wdata_1),
    .wgnt_0    (wgnt_0),
    .wgnt_1    (wgnt_1),
    .rreq_0    (rreq_0),
    .rreq_1    (rreq_1),
    .raddr_0   (raddr_0),
    .raddr_1   (raddr_1),
    .rgnt_0    (rgnt_0),
    .rgnt_1    (rgnt_1),
    .rvalid_0  (rvalid_0),
    .rvalid_1  (rvalid_1),
    .rdata     (rdata),
    .mem_wr    (mem_wr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read returns pre-write contents on a same-address collision.
  logic [DW-1:0] ram [32];
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
    mem_dout = '0;
  end
  always @(posedge clk) begin
    if (mem_rd) mem_dout <= ram[mem_raddr];
    if (mem_wr) ram[mem_waddr] <= mem_wdata;
  end

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } wr_exp_t;

  rd_exp_t rq[$];
  wr_exp_t wq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_exp_t e;
    e.addr = addr;
    e.data = data;
    e.due  = cyc + 1;
    wq.push_back(e);
  endtask

  task automatic expect_read(input logic id, input logic [DW-1:0] data);
    rd_exp_t e;
    e.id   = id;
    e.data = data;
    e.due  = cyc + 2;
    rq.push_back(e);
  endtask

  // Inputs are set 1 time unit after the edge; grants are checked 1 unit later, then one cycle passes.
  task automatic step(input logic [1:0] exp_w, input logic [1:0] exp_r, input string name);
    #1;
    check({name, "_wgnt"}, {30'd0, wgnt_1, wgnt_0}, {30'd0, exp_w});
    check({name, "_rgnt"}, {30'd0, rgnt_1, rgnt_0}, {30'd0, exp_r});
    @(posedge clk);
    #1;
  endtask

  // Monitor: pairs every rvalid / mem_wr cycle with the oldest queued expectation.
  always @(negedge clk) begin
    while (rq.size() > 0 && rq[0].due < cyc) begin
      check("rd_missing", 32'(cyc), 32'(rq[0].due));
      void'(rq.pop_front());
    end
    while (wq.size() > 0 && wq[0].due < cyc) begin
      check("wr_missing", 32'(cyc), 32'(wq[0].due));
      void'(wq.pop_front());
    end
    if (rvalid_0 && rvalid_1)
      check("rvalid_onehot", {30'd0, rvalid_1, rvalid_0}, 32'd1);
    if (rvalid_0 || rvalid_1) begin
      if (rq.size() == 0) begin
        check("rd_unexpected", {30'd0, rvalid_1, rvalid_0}, 32'd0);
      end else if (rq[0].due != cyc) begin
        check("rd_early", 32'(cyc), 32'(rq[0].due));
      end else begin
        rd_exp_t e;
        e = rq.pop_front();
        check("rd_id", {31'd0, rvalid_1}, {31'd0, e.id});
        check("rd_data", {16'd0, rdata}, {16'd0, e.data});
      end
    end
    if (mem_wr) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", {31'd0, mem_wr}, 32'd0);
      end else if (wq[0].due != cyc) begin
        check("wr_early", 32'(cyc), 32'(wq[0].due));
      end else begin
        wr_exp_t e;
        e = wq.pop_front();
        check("wr_addr", {27'd0, mem_waddr}, {27'd0, e.addr});
        check("wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wreq_0 = 1'b1; waddr_0 = 5'd0; wdata_0 = 16'h1111;
    wreq_1 = 1'b1; waddr_1 = 5'd1; wdata_1 = 16'h2222;
    rreq_0 = 1'b1; raddr_0 = 5'd2;
    rreq_1 = 1'b1; raddr_1 = 5'd3;

    // Reset held with every request high.
    repeat (3) @(posedge clk);
    #2;
    check("rst_wgnt", {30'd0, wgnt_1, wgnt_0}, 32'd0);
    check("rst_rgnt", {30'd0, rgnt_1, rgnt_0}, 32'd0);
    check("rst_cmd", {30'd0, mem_wr, mem_rd}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);
    check("rst_waddr", {27'd0, mem_waddr}, 32'd0);
    rst = 1'b0;

    // First contended grants go to requester 0, then requester 1 takes its turn.
    expect_write(5'd0, 16'h1111);
    expect_read(1'b0, 16'h0000);
    step(2'b01, 2'b01, "rel0");
    wreq_0 = 1'b0; rreq_0 = 1'b0;
    expect_write(5'd1, 16'h2222);
    expect_read(1'b1, 16'h0000);
    step(2'b10, 2'b10, "rel1");

    // Single write then read of the same word.
    wreq_1 = 1'b0; rreq_1 = 1'b0;
    wreq_0 = 1'b1; waddr_0 = 5'd5; wdata_0 = 16'hAABB;
    expect_write(5'd5, 16'hAABB);
    step(2'b01, 2'b00, "sw_w");
    wreq_0 = 1'b0;
    step(2'b00, 2'b00, "sw_gap");
    rreq_1 = 1'b1; raddr_1 = 5'd5;
    expect_read(1'b1, 16'hAABB);
    step(2'b00, 2'b10, "sw_r");
    rreq_1 = 1'b0;
    wreq_1 = 1'b1; waddr_1 = 5'd11; wdata_1 = 16'h0F0F;
    expect_write(5'd11, 16'h0F0F);
    step(2'b10, 2'b00, "sw_w1");

    // Write contention: grants alternate 0,1,0,1.
    wreq_0 = 1'b1; waddr_0 = 5'd9;  wdata_0 = 16'h1357;
    wreq_1 = 1'b1; waddr_1 = 5'd10; wdata_1 = 16'h9999;
    expect_write(5'd9, 16'h1357);
    step(2'b01, 2'b00, "ct0");
    wdata_0 = 16'hABCD;
    expect_write(5'd10, 16'h9999);
    step(2'b10, 2'b00, "ct1");
    wdata_1 = 16'h2525;
    expect_write(5'd9, 16'hABCD);
    step(2'b01, 2'b00, "ct2");
    expect_write(5'd10, 16'h2525);
    step(2'b10, 2'b00, "ct3");

    // Back-to-back reads from requester 0.
    wreq_0 = 1'b0; wreq_1 = 1'b0;
    rreq_0 = 1'b1; raddr_0 = 5'd5;
    expect_read(1'b0, 16'hAABB);
    step(2'b00, 2'b01, "pr0");
    raddr_0 = 5'd9;
    expect_read(1'b0, 16'hABCD);
    step(2'b00, 2'b01, "pr1");
    raddr_0 = 5'd10;
    expect_read(1'b0, 16'h2525);
    step(2'b00, 2'b01, "pr2");

    // Read contention with pointer at requester 1.
    raddr_0 = 5'd1;
    rreq_1 = 1'b1; raddr_1 = 5'd11;
    expect_read(1'b1, 16'h0F0F);
    step(2'b00, 2'b10, "rc0");
    rreq_1 = 1'b0;
    expect_read(1'b0, 16'h2222);
    step(2'b00, 2'b01, "rc1");

    // Same-cycle write and read of address 10.
    raddr_0 = 5'd10;
    wreq_0 = 1'b1; waddr_0 = 5'd10; wdata_0 = 16'h1234;
    expect_write(5'd10, 16'h1234);
`ifdef DPRAM_ARB_FWD_EN
    expect_read(1'b0, 16'h1234);
`else
    expect_read(1'b0, 16'h2525);
`endif
    step(2'b01, 2'b01, "col");
    wreq_0 = 1'b0;
    expect_read(1'b0, 16'h1234);
    step(2'b00, 2'b01, "col_next");
    rreq_0 = 1'b0;
    step(2'b00, 2'b00, "idle");

    // Reset pulse while a read is in flight: it must never return.
    rreq_1 = 1'b1; raddr_1 = 5'd5;
    step(2'b00, 2'b10, "mr_gnt");
    check("mr_rd_issued", {31'd0, mem_rd}, 32'd1);
    rreq_1 = 1'b0;
    wreq_0 = 1'b1;
    rst = 1'b1;
    #1;
    check("mr_cmd", {30'd0, mem_wr, mem_rd}, 32'd0);
    check("mr_waddr", {27'd0, mem_waddr}, 32'd0);
    check("mr_wdata", {16'd0, mem_wdata}, 32'd0);
    check("mr_raddr", {27'd0, mem_raddr}, 32'd0);
    check("mr_wgnt", {30'd0, wgnt_1, wgnt_0}, 32'd0);
    check("mr_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);
    #1;
    rst = 1'b0;
    wreq_0 = 1'b0;
    @(posedge clk);
    #1;
    check("mr_no_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);

    // Pointers restart at requester 0 after reset.
    wreq_0 = 1'b1; waddr_0 = 5'd0; wdata_0 = 16'hBEEF;
    wreq_1 = 1'b1; waddr_1 = 5'd1; wdata_1 = 16'hCAFE;
    rreq_0 = 1'b1; raddr_0 = 5'd11;
    rreq_1 = 1'b1; raddr_1 = 5'd9;
    expect_write(5'd0, 16'hBEEF);
    expect_read(1'b0, 16'h0F0F);
    step(2'b01, 2'b01, "pr_rst");
    wreq_0 = 1'b0; wreq_1 = 1'b0; rreq_0 = 1'b0; rreq_1 = 1'b0;
    repeat (4) step(2'b00, 2'b00, "drain");

    check("rd_queue_empty", 32'(rq.size()), 32'd0);
    check("wr_queue_empty", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Two-requester arbiter and sequencer for the 32x16 dual-port RAM (separate write port and read port, full duplex). Write requesters share the RAM write port and read requesters share the RAM read port, each through an independent round-robin arbiter with a req/gnt handshake. Registered commands drive the RAM, and read data is returned to the owning requester with a valid strobe. Sits between client logic and the `mem` instance; one write and one read can be issued every cycle.

## Interface
- AW, 5, address width (32 words)
- DW, 16, data width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wreq_0 / wreq_1  in  1  write request, held until granted
- waddr_0 / waddr_1  in  AW  write address
- wdata_0 / wdata_1  in  DW  write data
- wgnt_0 / wgnt_1  out  1  write grant, combinational, at most one high
- rreq_0 / rreq_1  in  1  read request, held until granted
- raddr_0 / raddr_1  in  AW  read address
- rgnt_0 / rgnt_1  out  1  read grant, combinational, at most one high
- rvalid_0 / rvalid_1  out  1  read data valid for requester k
- rdata  out  DW  read data, shared, qualified by rvalid_k
- mem_wr, mem_waddr[AW], mem_wdata[DW]  out  RAM write command (registered)
- mem_rd, mem_raddr[AW]  out  RAM read command (registered)
- mem_dout  in  DW  RAM read data, registered inside RAM on the edge where mem_rd=1

## Operation
- Write arbiter and read arbiter are identical and independent. Each has a 1-bit priority pointer `wptr` / `rptr`.
- Grant rule:
  - Single requester: that requester is granted.
  - Both requesting: the requester indexed by the pointer is granted.
  - No request: no grant.
- After any grant to k, the pointer becomes 1-k. With no grant, the pointer holds.
- A transfer occurs when req_k && gnt_k. The requester may change addr/data or drop req on the next cycle.
- Write path: on a granted edge, mem_wr<=1 and mem_waddr/mem_wdata<=winner's addr/data. Otherwise mem_wr<=0 and address/data hold.
- Read path: on a granted edge, mem_rd<=1, mem_raddr<=winner's addr, and a tag (valid, id) enters a 2-stage pipeline. Otherwise mem_rd<=0.
- Read return: rvalid_id=1 when the tag exits the pipeline. rdata=mem_dout in that cycle. rdata is don't-care when no rvalid is high.
- Collision (mem_wr && mem_rd && mem_waddr==mem_raddr in the same cycle): the RAM returns pre-write data. See Configuration.
- All grants are forced to 0 while rst=1.
- Out-of-range addresses cannot occur (AW bits fully decode).

## Timing
- Reset values: wgnt_*=0, rgnt_*=0, mem_wr=0, mem_rd=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, rvalid_*=0, wptr=0, rptr=0 (requester 0 has first priority).
- Write latency: gnt in cycle T, mem_wr high in T+1, RAM updated at the end-of-T+1 edge.
- Read latency: gnt in cycle T, mem_rd high in T+1, rvalid_k/rdata in T+2. Fixed 2 cycles.
- Throughput: 1 write + 1 read per cycle. Back-to-back reads pipeline with no bubbles.
- Contended steady state: grants alternate 0,1,0,1...
- Reset asserted mid-operation: in-flight reads are discarded and no rvalid is issued for them. Pending commands are cleared immediately (asynchronous).
- A write granted in cycle T is visible to a read granted in T+1 or later, or to a read granted in T with the same address when forwarding is enabled.

## Configuration
- `DPRAM_ARB_FWD_EN` defined:
  - On a collision in cycle T+1, a registered flag plus the registered mem_wdata are carried with the read tag.
  - rdata in T+2 returns the new write data instead of mem_dout.
- Not defined: no forwarding logic. rdata is always mem_dout, so a colliding read returns the old contents.

## Test plan
- **Reset:** rst=1 with all reqs high -> all gnts, mem_wr, mem_rd and rvalids are 0. Release -> first contended grant goes to requester 0.
- **Single write then read:** wreq_0 @5 data 16'hAABB; two cycles later rreq_1 @5 -> mem_wr pulse with waddr 5; rvalid_1 high 2 cycles after rgnt_1 with rdata=16'hAABB; rvalid_0 stays 0.
- **Contention fairness:** wreq_0 and wreq_1 held for 4 grants (@9=16'hABCD, @10=16'h2525, ...) -> wgnt order 0,1,0,1; RAM holds the last value written per address.
- **Pipelined reads:** rreq_0 @5, @9, @10 on consecutive cycles -> three consecutive rvalid_0 cycles returning AABB, ABCD, 2525 in order.
- **Collision:** same-cycle grant of write @10=16'h1234 (old value 16'h2525) and read @10 -> rdata=16'h1234 with `DPRAM_ARB_FWD_EN`, 16'h2525 without.
- **Reset mid-read:** rgnt issued, then rst pulses in T+1 -> no rvalid in T+2; all outputs return to reset values.
